// File: rtl/pc_pkg.sv
// Shared definitions for the fetch PC sequencer: redirect-select encoding and default sizing.
package pc_pkg;
  localparam int PC_WIDTH = 32;
  localparam int PC_INCR  = 1;

  localparam logic [2:0] SEL_INC  = 3'd0;
  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_CALL = 3'd2;
  localparam logic [2:0] SEL_RET  = 3'd3;
  localparam logic [2:0] SEL_HOLD = 3'd4;
endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry.
module ras_stack #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [CW-1:0]    r_count;
  logic [PW-1:0]    w_top_idx;
  logic [PW-1:0]    w_wp_inc;

  // r_wp names the next free slot; once full it also names the oldest entry.
  assign w_top_idx = (r_wp == '0) ? PW'(DEPTH-1) : r_wp - 1'b1;
  assign w_wp_inc  = (r_wp == PW'(DEPTH-1)) ? '0 : r_wp + 1'b1;

  assign top   = r_mem[w_top_idx];
  assign count = r_count;
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_count <= '0;
    end else if (push) begin
      r_wp <= w_wp_inc;
      if (!full) r_count <= r_count + 1'b1;
    end else if (pop && !empty) begin
      r_wp    <= w_top_idx;
      r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) r_mem[r_wp] <= din;
  end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with stall, branch, call/return and a circular RAS.
// Optional PC_TRACE_EN macro compiles a per-cycle simulation trace.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int               WIDTH    = PC_WIDTH,
  parameter int               INCR     = PC_INCR,
  parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b1}},
  parameter int               DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       branch,
  input  logic                       call,
  input  logic                       ret,
  input  logic [WIDTH-1:0]           pc_next,
  output logic [WIDTH-1:0]           pc,
  output logic [$clog2(DEPTH+1)-1:0] ras_count,
  output logic                       ras_empty,
  output logic                       ras_full,
  output logic                       ras_ovf,
  output logic                       ras_udf
);
  logic [WIDTH-1:0] r_pc;
  logic             r_ovf;
  logic             r_udf;
  logic [2:0]       w_sel;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_top;
  logic             w_push;
  logic             w_pop;

  assign w_inc = r_pc + WIDTH'(INCR);

  always_comb begin
    w_sel = SEL_INC;
    if (stall)       w_sel = SEL_HOLD;
    else if (ret)    w_sel = SEL_RET;
    else if (call)   w_sel = SEL_CALL;
    else if (branch) w_sel = SEL_BR;
  end

  assign w_push = (w_sel == SEL_CALL);
  assign w_pop  = (w_sel == SEL_RET) && !ras_empty;

  ras_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ras (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_inc),
    .top   (w_top),
    .count (ras_count),
    .full  (ras_full),
    .empty (ras_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= RESET_PC;
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      case (w_sel)
        SEL_HOLD: ;
        SEL_RET: begin
          // Popping an empty stack falls through to a sequential fetch.
          if (ras_empty) begin
            r_pc  <= w_inc;
            r_udf <= 1'b1;
          end else begin
            r_pc  <= w_top;
          end
        end
        SEL_CALL: begin
          r_pc <= pc_next;
          if (ras_full) r_ovf <= 1'b1;
        end
        SEL_BR:  r_pc <= pc_next;
        default: r_pc <= w_inc;
      endcase
    end
  end

  assign pc      = r_pc;
  assign ras_ovf = r_ovf;
  assign ras_udf = r_udf;

`ifdef PC_TRACE_EN
  always @(posedge clk)
    $strobe("%t: PC: %d, PC_NXT: %d, BRANCH %d CALL %d RET %d STALL %d DEPTH %d",
            $time, pc, pc_next, branch, call, ret, stall, ras_count);
`else
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// Table-driven directed bench for pc_sequencer (WIDTH=32, INCR=1, DEPTH=4).
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset, stall, branch, call, ret;
  logic [31:0] pc_next;
  logic [31:0] pc;
  logic [2:0]  ras_count;
  logic        ras_empty, ras_full, ras_ovf, ras_udf;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(.WIDTH(32), .INCR(1), .RESET_PC(32'hFFFF_FFFF), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .call(call), .ret(ret),
    .pc_next(pc_next), .pc(pc), .ras_count(ras_count), .ras_empty(ras_empty),
    .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_udf(ras_udf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl, br, cl, rt;
    logic [31:0] nxt;
    logic [31:0] pc;
    logic [2:0]  cnt;
    logic        ovf, udf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, stl, br, cl, rt, input logic [31:0] nxt,
                     input logic [31:0] epc, input logic [2:0] cnt, input logic ovf, udf);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.cl = cl; v.rt = rt; v.nxt = nxt;
    v.pc = epc; v.cnt = cnt; v.ovf = ovf; v.udf = udf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input logic rst, stl, br, cl, rt, input logic [31:0] nxt);
    @(negedge clk);
    reset = rst; stall = stl; branch = br; call = cl; ret = rt; pc_next = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc, input logic [2:0] cnt,
                           input logic ovf, input logic udf);
    chk({tag, " pc"},    pc,                32'(epc));
    chk({tag, " count"}, 32'(ras_count),    32'(cnt));
    chk({tag, " empty"}, 32'(ras_empty),    32'(cnt == 3'd0));
    chk({tag, " full"},  32'(ras_full),     32'(cnt == 3'd4));
    chk({tag, " ovf"},   32'(ras_ovf),      32'(ovf));
    chk({tag, " udf"},   32'(ras_udf),      32'(udf));
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; branch = 1'b0; call = 1'b0; ret = 1'b0; pc_next = '0;

    //   rst stl br cl rt  nxt            pc             cnt ovf udf
    add(1, 0, 0, 0, 0, 32'd0,          32'hFFFF_FFFF, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,          32'd0,         0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,          32'd1,         0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,          32'd2,         0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,          32'd3,         0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,          32'd4,         0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,          32'd5,         0, 0, 0);
    add(0, 0, 1, 0, 0, 32'd40,         32'd40,        0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,          32'd41,        0, 0, 0);
    add(0, 1, 1, 0, 0, 32'd7,          32'd41,        0, 0, 0);
    add(0, 1, 0, 0, 0, 32'd0,          32'd41,        0, 0, 0);
    add(0, 0, 1, 0, 0, 32'd10,         32'd10,        0, 0, 0);
    add(0, 0, 0, 1, 0, 32'd100,        32'd100,       1, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,          32'd101,       1, 0, 0);
    add(0, 0, 0, 1, 0, 32'd200,        32'd200,       2, 0, 0);
    add(0, 0, 0, 0, 1, 32'd0,          32'd102,       1, 0, 0);
    add(0, 0, 0, 0, 1, 32'd0,          32'd11,        0, 0, 0);
    add(0, 0, 1, 0, 0, 32'd0,          32'd0,         0, 0, 0);
    add(0, 0, 0, 1, 0, 32'd1,          32'd1,         1, 0, 0);
    add(0, 0, 0, 1, 0, 32'd2,          32'd2,         2, 0, 0);
    add(0, 0, 0, 1, 0, 32'd3,          32'd3,         3, 0, 0);
    add(0, 0, 0, 1, 0, 32'd4,          32'd4,         4, 0, 0);
    add(0, 0, 0, 1, 0, 32'd5,          32'd5,         4, 1, 0);
    add(0, 0, 0, 0, 1, 32'd0,          32'd5,         3, 1, 0);
    add(0, 0, 0, 0, 1, 32'd0,          32'd4,         2, 1, 0);
    add(0, 0, 0, 0, 1, 32'd0,          32'd3,         1, 1, 0);
    add(0, 0, 0, 0, 1, 32'd0,          32'd2,         0, 1, 0);
    add(0, 0, 0, 0, 1, 32'd0,          32'd3,         0, 1, 1);
    add(0, 0, 0, 1, 0, 32'd50,         32'd50,        1, 1, 1);
    add(0, 0, 0, 1, 0, 32'd60,         32'd60,        2, 1, 1);
    add(0, 0, 1, 1, 1, 32'd99,         32'd51,        1, 1, 1);
    add(0, 0, 1, 1, 0, 32'd77,         32'd77,        2, 1, 1);
    add(0, 0, 0, 0, 1, 32'd0,          32'd52,        1, 1, 1);
    add(0, 0, 1, 0, 0, 32'hFFFF_FFFE,  32'hFFFF_FFFE, 1, 1, 1);
    add(0, 0, 0, 0, 0, 32'd0,          32'hFFFF_FFFF, 1, 1, 1);
    add(0, 0, 0, 0, 0, 32'd0,          32'd0,         1, 1, 1);
    add(0, 0, 0, 1, 0, 32'd10,         32'd10,        2, 1, 1);
    add(0, 0, 0, 1, 0, 32'd20,         32'd20,        3, 1, 1);
    add(1, 0, 0, 1, 0, 32'd5,          32'hFFFF_FFFF, 0, 0, 0);
    add(0, 0, 0, 0, 0, 32'd0,          32'd0,         0, 0, 0);
    add(0, 0, 0, 0, 1, 32'd0,          32'd1,         0, 0, 1);

    foreach (vecs[i]) begin
      apply(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].cl, vecs[i].rt, vecs[i].nxt);
      check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].cnt, vecs[i].ovf, vecs[i].udf);
    end

    // Stall must freeze a pending return, then the pop resolves once released.
    apply(0, 0, 0, 1, 0, 32'd30);
    check_all("seq call", 32'd30, 3'd1, 1'b0, 1'b1);
    apply(0, 1, 0, 0, 1, 32'd0);
    check_all("seq stall-ret1", 32'd30, 3'd1, 1'b0, 1'b1);
    apply(0, 1, 0, 0, 1, 32'd0);
    check_all("seq stall-ret2", 32'd30, 3'd1, 1'b0, 1'b1);
    apply(0, 0, 0, 0, 1, 32'd0);
    check_all("seq ret", 32'd2, 3'd0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
